// File: rtl/fcims_pkg.sv
// Shared definitions for the sequential food-court inventory unit:
// opcodes, FSM state encoding and a saturating adder.
package fcims_pkg;

  localparam logic OP_RESTOCK = 1'b0;
  localparam logic OP_SELL    = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StMul,
    StDone
  } fcims_state_e;

  localparam int unsigned SatW = 64;

  // Returns min(a + b, 2^width - 1); callers zero-extend operands to SatW bits.
  function automatic logic [SatW-1:0] sat_add(input logic [SatW-1:0] a,
                                              input logic [SatW-1:0] b,
                                              input int unsigned     width);
    logic [SatW:0] sum;
    logic [SatW:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SatW + 1)'(1) << width) - (SatW + 1)'(1);
    return (sum > lim) ? lim[SatW-1:0] : sum[SatW-1:0];
  endfunction

endpackage

// File: rtl/fcims_seq_if.sv
// Request/response bundle between the counter front-end (master) and
// the inventory sequencer (slave).
interface fcims_seq_if #(
  parameter int unsigned N_ITEMS = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned TOTAL_W = 12
);
  localparam int unsigned IdxW  = $clog2(N_ITEMS);
  localparam int unsigned ProdW = PRICE_W + CNT_W;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_op;
  logic [IdxW-1:0]            req_item;
  logic [CNT_W-1:0]           req_qty;
  logic [PRICE_W-1:0]         req_uprice;
  logic                       bill_clear;
  logic                       resp_valid;
  logic                       resp_ok;
  logic [ProdW-1:0]           resp_price;
  logic [CNT_W-1:0]           resp_stock;
  logic [TOTAL_W-1:0]         bill_total;
  logic [N_ITEMS*CNT_W-1:0]   stock_flat;

  modport master (
    output req_valid, req_op, req_item, req_qty, req_uprice, bill_clear,
    input  req_ready, resp_valid, resp_ok, resp_price, resp_stock, bill_total, stock_flat
  );

  modport slave (
    input  req_valid, req_op, req_item, req_qty, req_uprice, bill_clear,
    output req_ready, resp_valid, resp_ok, resp_price, resp_stock, bill_total, stock_flat
  );

endinterface

// File: rtl/fcims_shift_mult.sv
// Unsigned shift-add multiplier: the LSB partial product is folded in at start,
// so done rises exactly CNT_W cycles after start with the full product ready.
module fcims_shift_mult #(
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_i,
  input  logic [PRICE_W-1:0]         uprice_i,
  input  logic [CNT_W-1:0]           qty_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [PRICE_W+CNT_W-1:0]   product_o
);

  localparam int unsigned ProdW   = PRICE_W + CNT_W;
  localparam int unsigned CntBits = $clog2(CNT_W + 1);

  logic [ProdW-1:0]   mcand_q;
  logic [ProdW-1:0]   acc_q;
  logic [CNT_W-1:0]   mplier_q;
  logic [CntBits-1:0] left_q;
  logic               busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      left_q   <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= ProdW'(uprice_i) << 1;
      mplier_q <= qty_i >> 1;
      acc_q    <= qty_i[0] ? ProdW'(uprice_i) : '0;
      left_q   <= CntBits'(CNT_W - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (left_q != '0) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        left_q   <= left_q - CntBits'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (left_q == '0);
  assign product_o = acc_q;

endmodule

// File: rtl/fcims_seq.sv
// Sequential multi-item inventory: one restock/sale transaction at a time,
// sales priced by a shift-add multiplier and accumulated into a saturating bill.
module fcims_seq
  import fcims_pkg::*;
#(
  parameter int unsigned N_ITEMS = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned TOTAL_W = 12
) (
  input logic        clk,
  input logic        reset_n,
  fcims_seq_if.slave bus
);

  localparam int unsigned IdxW  = $clog2(N_ITEMS);
  localparam int unsigned ProdW = PRICE_W + CNT_W;

  fcims_state_e       state_q;
  logic               op_q;
  logic [IdxW-1:0]    item_q;
  logic [CNT_W-1:0]   qty_q;
  logic [PRICE_W-1:0] uprice_q;
  logic [CNT_W-1:0]   res_stock_q;
  logic [CNT_W-1:0]   stock_q [N_ITEMS];
  logic [TOTAL_W-1:0] total_q, total_d, total_base;
  logic               resp_valid_q, resp_ok_q;
  logic [ProdW-1:0]   resp_price_q;
  logic [CNT_W-1:0]   resp_stock_q;

  logic               item_ok, sell_ok, restock_ok, accept, stock_we;
  logic [CNT_W-1:0]   cur_stock, stock_wdata;
  logic [CNT_W:0]     restock_sum;
  logic               mul_start, mul_busy, mul_done;
  logic [ProdW-1:0]   mul_product;

  always_comb begin
    item_ok   = 32'(item_q) < N_ITEMS;
    cur_stock = '0;
    if (item_ok) begin
      cur_stock = stock_q[item_q];
    end
    restock_sum = {1'b0, cur_stock} + {1'b0, qty_q};
    sell_ok     = item_ok && (qty_q <= cur_stock);
    restock_ok  = item_ok && !restock_sum[CNT_W];
    accept      = (op_q == OP_SELL) ? sell_ok : restock_ok;
    stock_we    = (state_q == StCheck) && accept;
    stock_wdata = (op_q == OP_SELL) ? (cur_stock - qty_q) : restock_sum[CNT_W-1:0];
    mul_start   = stock_we && (op_q == OP_SELL) && !mul_busy;

    // Clear wins over the old total but not over the sale completing this cycle.
    total_base = bus.bill_clear ? '0 : total_q;
    total_d    = total_base;
    if ((state_q == StDone) && resp_ok_q && (op_q == OP_SELL)) begin
      total_d = TOTAL_W'(sat_add(SatW'(total_base), SatW'(resp_price_q), TOTAL_W));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stock_q <= '{default: '0};
    end else if (stock_we) begin
      stock_q[item_q] <= stock_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      op_q         <= OP_RESTOCK;
      item_q       <= '0;
      qty_q        <= '0;
      uprice_q     <= '0;
      res_stock_q  <= '0;
      total_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_price_q <= '0;
      resp_stock_q <= '0;
    end else begin
      total_q      <= total_d;
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            op_q     <= bus.req_op;
            item_q   <= bus.req_item;
            qty_q    <= bus.req_qty;
            uprice_q <= bus.req_uprice;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          res_stock_q <= stock_we ? stock_wdata : cur_stock;
          if (mul_start) begin
            state_q <= StMul;
          end else begin
            resp_valid_q <= 1'b1;
            resp_ok_q    <= accept;
            resp_price_q <= '0;
            resp_stock_q <= stock_we ? stock_wdata : cur_stock;
            state_q      <= StDone;
          end
        end
        StMul: begin
          if (mul_done) begin
            resp_valid_q <= 1'b1;
            resp_ok_q    <= 1'b1;
            resp_price_q <= mul_product;
            resp_stock_q <= res_stock_q;
            state_q      <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  fcims_shift_mult #(
    .PRICE_W(PRICE_W),
    .CNT_W  (CNT_W)
  ) u_mult (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (mul_start),
    .uprice_i (uprice_q),
    .qty_i    (qty_q),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ok    = resp_ok_q;
  assign bus.resp_price = resp_price_q;
  assign bus.resp_stock = resp_stock_q;
  assign bus.bill_total = total_q;

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_flat
    assign bus.stock_flat[g*CNT_W +: CNT_W] = stock_q[g];
  end

endmodule

// File: tb/tb_fcims_seq.sv
// Scoreboard bench for fcims_seq: a default instance and a 5-item / 8-bit-total
// instance share stimulus wires; sel picks which one is driven and observed.
module tb_fcims_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  bit         sel = 1'b0;
  logic       t_valid = 1'b0;
  logic       t_op = 1'b0;
  logic [2:0] t_item = '0;
  logic [3:0] t_qty = '0;
  logic [3:0] t_up = '0;
  logic       t_clear = 1'b0;

  logic        o_valid, o_ready, o_ok;
  logic [7:0]  o_price;
  logic [3:0]  o_stock;
  logic [11:0] o_total;
  logic [19:0] o_flat;

  typedef struct {
    int ok;
    int price;
    int stock;
    int lat;
    int total;
    bit chk_stock;
    bit clr;
  } exp_t;

  exp_t sb[$];
  int   ref_stock [2][5];
  int   ref_total [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fcims_seq_if #(.N_ITEMS(4), .CNT_W(4), .PRICE_W(4), .TOTAL_W(12)) if_a ();
  fcims_seq_if #(.N_ITEMS(5), .CNT_W(4), .PRICE_W(4), .TOTAL_W(8))  if_b ();

  fcims_seq #(.N_ITEMS(4), .CNT_W(4), .PRICE_W(4), .TOTAL_W(12)) u_dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (if_a)
  );

  fcims_seq #(.N_ITEMS(5), .CNT_W(4), .PRICE_W(4), .TOTAL_W(8)) u_dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (if_b)
  );

  assign if_a.req_valid  = t_valid && !sel;
  assign if_a.req_op     = t_op;
  assign if_a.req_item   = t_item[1:0];
  assign if_a.req_qty    = t_qty;
  assign if_a.req_uprice = t_up;
  assign if_a.bill_clear = t_clear && !sel;
  assign if_b.req_valid  = t_valid && sel;
  assign if_b.req_op     = t_op;
  assign if_b.req_item   = t_item;
  assign if_b.req_qty    = t_qty;
  assign if_b.req_uprice = t_up;
  assign if_b.bill_clear = t_clear && sel;

  always_comb begin
    o_valid = sel ? if_b.resp_valid : if_a.resp_valid;
    o_ready = sel ? if_b.req_ready  : if_a.req_ready;
    o_ok    = sel ? if_b.resp_ok    : if_a.resp_ok;
    o_price = sel ? if_b.resp_price : if_a.resp_price;
    o_stock = sel ? if_b.resp_stock : if_a.resp_stock;
    o_total = sel ? {4'b0, if_b.bill_total} : if_a.bill_total;
    o_flat  = sel ? if_b.stock_flat : {4'b0, if_a.stock_flat};
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s (dut %0d, cycle %0d): got %0d, want %0d", tag, sel, cyc, got, exp);
    end
  endtask

  function automatic logic [19:0] model_flat();
    logic [19:0] f;
    f = '0;
    for (int i = 0; i < 5; i++) f[i*4 +: 4] = 4'(ref_stock[int'(sel)][i]);
    return f;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      ref_total[d] = 0;
      for (int i = 0; i < 5; i++) ref_stock[d][i] = 0;
    end
    sb.delete();
  endfunction

  // Handshake in the current cycle T; returns at the negedge of T+1.
  task automatic issue(input bit op, input int item, input int qty, input int up,
                       input bit clr, output int t0);
    exp_t e;
    int   n, tmax, s, w;
    w = 0;
    while (!o_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_req", int'(o_ready), 1);
    n    = sel ? 5 : 4;
    tmax = sel ? 255 : 4095;
    t_op = op; t_item = 3'(item); t_qty = 4'(qty); t_up = 4'(up);
    t_valid = 1'b1;
    t0 = cyc;
    e.ok = 0; e.price = 0; e.stock = 0; e.lat = 2; e.chk_stock = 1'b1; e.clr = clr;
    if (item >= n) begin
      e.chk_stock = 1'b0;
    end else begin
      s = ref_stock[int'(sel)][item];
      if (op) begin
        if (qty <= s) begin
          e.ok = 1; s -= qty; e.price = up * qty; e.lat = 6;
        end
      end else if (s + qty <= 15) begin
        e.ok = 1; s += qty;
      end
      ref_stock[int'(sel)][item] = s;
      e.stock = s;
    end
    if (clr) ref_total[int'(sel)] = 0;
    if (e.ok != 0 && op) begin
      ref_total[int'(sel)] += e.price;
      if (ref_total[int'(sel)] > tmax) ref_total[int'(sel)] = tmax;
    end
    e.total = ref_total[int'(sel)];
    sb.push_back(e);
    @(negedge clk);
    t_valid = 1'b0;
  endtask

  task automatic complete(input int t0);
    exp_t e;
    int   w, rdy_hi;
    rdy_hi = 0;
    if (o_ready) rdy_hi++;
    @(negedge clk);
    check_eq("stock_flat_t2", int'(o_flat), int'(model_flat()));
    w = 0;
    while (!o_valid && w < 40) begin
      if (o_ready) rdy_hi++;
      @(negedge clk);
      w++;
    end
    if (o_ready) rdy_hi++;
    check_eq("resp_valid", int'(o_valid), 1);
    check_eq("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("latency", cyc - t0, e.lat);
      check_eq("resp_ok", int'(o_ok), e.ok);
      check_eq("resp_price", int'(o_price), e.price);
      if (e.chk_stock) check_eq("resp_stock", int'(o_stock), e.stock);
      check_eq("ready_low_cycles", rdy_hi, 0);
      if (e.clr) t_clear = 1'b1;
      @(negedge clk);
      t_clear = 1'b0;
      check_eq("valid_pulse", int'(o_valid), 0);
      check_eq("ready_back", int'(o_ready), 1);
      check_eq("bill_total", int'(o_total), e.total);
      check_eq("price_hold", int'(o_price), e.price);
    end
  endtask

  task automatic txn(input bit op, input int item, input int qty, input int up, input bit clr);
    int t0;
    issue(op, item, qty, up, clr, t0);
    complete(t0);
  endtask

  task automatic check_idle_state(input string tag);
    check_eq({tag, "_ready"}, int'(o_ready), 1);
    check_eq({tag, "_valid"}, int'(o_valid), 0);
    check_eq({tag, "_flat"}, int'(o_flat), int'(model_flat()));
    check_eq({tag, "_total"}, int'(o_total), ref_total[int'(sel)]);
  endtask

  initial begin
    int t0, pulses;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      sel = bit'(d);
      #1;
      check_idle_state("reset");
      check_eq("reset_ok", int'(o_ok), 0);
      check_eq("reset_price", int'(o_price), 0);
      check_eq("reset_stock", int'(o_stock), 0);
    end
    sel = 1'b0;
    @(negedge clk);

    // Default instance: directed sequence then random traffic.
    txn(1'b0, 2, 9, 0, 1'b0);
    txn(1'b1, 2, 3, 13, 1'b0);
    txn(1'b1, 2, 7, 5, 1'b0);
    txn(1'b0, 2, 9, 0, 1'b0);
    txn(1'b0, 2, 1, 0, 1'b0);
    txn(1'b0, 0, 5, 0, 1'b0);
    txn(1'b1, 0, 0, 7, 1'b0);
    txn(1'b1, 3, 1, 9, 1'b0);
    txn(1'b1, 3, 0, 9, 1'b0);
    for (int k = 0; k < 24; k++) begin
      txn(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
    end
    t_clear = 1'b1;
    @(negedge clk);
    t_clear = 1'b0;
    ref_total[0] = 0;
    check_eq("idle_clear", int'(o_total), 0);

    // Narrow-total, 5-item instance.
    sel = 1'b1;
    @(negedge clk);
    txn(1'b0, 1, 15, 0, 1'b0);
    txn(1'b1, 1, 15, 15, 1'b0);
    txn(1'b0, 1, 15, 0, 1'b0);
    txn(1'b1, 1, 15, 15, 1'b0);
    txn(1'b0, 4, 5, 0, 1'b0);
    txn(1'b1, 4, 2, 3, 1'b1);
    txn(1'b0, 5, 3, 0, 1'b0);
    txn(1'b1, 7, 1, 1, 1'b0);

    // Reset during the second MUL cycle of a sale.
    txn(1'b0, 0, 8, 0, 1'b0);
    issue(1'b1, 0, 2, 5, 1'b0, t0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("abort_flat", int'(o_flat), 0);
    check_eq("abort_total", int'(o_total), 0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    check_eq("abort_no_resp", pulses, 0);
    check_idle_state("post_abort_b");
    sel = 1'b0;
    #1;
    check_idle_state("post_abort_a");
    sel = 1'b1;
    @(negedge clk);
    txn(1'b0, 3, 4, 0, 1'b0);
    txn(1'b1, 3, 4, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fcims_seq.md
# fcims_seq

Sequential, multi-item successor to the combinational food-court inventory unit. It holds a stock count for each of `N_ITEMS` items and processes one transaction at a time over a valid/ready request interface. A transaction is either a restock (add) or a sale (subtract with underflow rejection). For a sale, a multi-cycle shift-add multiplier prices the order, and the price is accumulated into a saturating bill total. It sits between the counter front-end and the billing display.

## Interface
- `N_ITEMS`, default 4: number of item channels; minimum 2.
- `CNT_W`, default 4: width of stock counts and quantities.
- `PRICE_W`, default 4: width of the unit price.
- `TOTAL_W`, default 12: width of the bill accumulator; must be ≥ `PRICE_W+CNT_W`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_op` in 1: 0 = restock, 1 = sell.
- `req_item` in `$clog2(N_ITEMS)`: item index.
- `req_qty` in `CNT_W`: quantity.
- `req_uprice` in `PRICE_W`: unit price (used only by sell).
- `bill_clear` in 1: synchronous clear of `bill_total`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_ok` out 1: transaction applied (1) or rejected (0).
- `resp_price` out `PRICE_W+CNT_W`: order price; 0 for restock or reject.
- `resp_stock` out `CNT_W`: stock of the addressed item after the transaction.
- `bill_total` out `TOTAL_W`: running saturating total of sale prices.
- `stock_flat` out `N_ITEMS*CNT_W`: all stock registers; item i occupies bits `[i*CNT_W +: CNT_W]`.

## Operation
- FSM states: IDLE, CHECK, MUL, DONE. `req_ready` is 1 only in IDLE.
- A handshake (`req_valid && req_ready`) latches op, item, qty and uprice, then moves IDLE→CHECK.
- CHECK decides the outcome:
  - Item index ≥ `N_ITEMS`: reject → DONE.
  - Sell with qty > stock: reject → DONE.
  - Sell with qty ≤ stock: stock −= qty, start the multiplier → MUL.
  - Restock where stock+qty > 2^CNT_W−1: reject → DONE.
  - Restock otherwise: stock += qty → DONE.
- On reject, stock and total are unchanged.
- MUL lasts exactly `CNT_W` cycles: unsigned shift-add of `uprice × qty`, giving an exact `PRICE_W+CNT_W`-bit product. A zero quantity still takes the full `CNT_W` cycles and yields 0.
- DONE:
  - `resp_*` are valid for that cycle.
  - On a successful sale, `bill_total` += price, saturating at 2^TOTAL_W−1.
  - Next state is IDLE.
- `bill_clear`, in any state, sets `bill_total` to 0. If it coincides with a DONE accumulation, the result is `bill_total` = that sale's price (clear first, then add).
- The `resp_*` outputs hold their last values outside DONE. Only `resp_valid` pulses.

## Timing
- Reset values: all stock = 0, `bill_total` = 0, `resp_valid` = 0, `resp_ok` = 0, `resp_price` = 0, `resp_stock` = 0, FSM in IDLE, `req_ready` = 1 once `reset_n` deasserts.
- For a handshake in cycle T:
  - Stock updates at the end of T+1.
  - Restock or reject: `resp_valid` in T+2, `req_ready` back in T+3.
  - Successful sell: `resp_valid` in T+2+`CNT_W`, `req_ready` in T+3+`CNT_W`.
- Throughput is one transaction at a time. `req_valid` while not ready is ignored and must be held by the source.
- Asserting `reset_n` low in any state, including mid-MUL, aborts the transaction immediately. Nothing partial is committed beyond what CHECK already wrote before the reset. All registers return to their reset values.

## Structure
- Package `fcims_pkg`: op encodings `OP_RESTOCK`=0 and `OP_SELL`=1, the FSM state typedef, and a saturating-add helper function.
- Sub-module `fcims_shift_mult` (parameters `PRICE_W`, `CNT_W`):
  - Ports: `start`, operands, `busy`, `done`, `product`.
  - Takes exactly `CNT_W` cycles from start to done.
  - Shares `clk`/`reset_n` with the parent.
- Stock is held as an array of `N_ITEMS` registers with a single write port driven by CHECK.

## Test plan
- Reset, then restock item 2 by qty 9 → `resp_ok`=1, `resp_stock`=9, `resp_price`=0, `resp_valid` at T+2, `bill_total`=0.
- Then sell item 2, qty 3, uprice 13 → `resp_ok`=1, price 39, stock 6, `bill_total`=39, `resp_valid` at T+6, `req_ready` low from T+1 through T+6.
- Sell item 2 qty 7 (stock 6) → `resp_ok`=0, price 0, stock 6, total stays 39. Then restock item 2 by 9 → stock 15; then restock by 1 → reject, stock stays 15.
- With `TOTAL_W`=8: two sells of qty 15 × uprice 15 on a stocked item → totals 225, then 255 (saturated). Then `bill_clear` asserted in the DONE cycle of a sale of 2×3 → `bill_total`=6.
- Assert `reset_n` low in the second MUL cycle of a sale → `resp_valid` never pulses, all stock=0, `bill_total`=0, `req_ready`=1 after release.
- Request with `req_item`=5 using `N_ITEMS`=5 (index width 3) → `resp_ok`=0 at T+2, no `stock_flat` change.
